imem_fetch_ctrl: RTL and testbench
==================================

Name: imem_fetch_ctrl

Overview:
Fetch sequencer for the 16-bit CPU's combinational instruction ROM (16-bit word address, OE, 16-bit data). It owns the program counter, drives the ROM address and OE, and captures fetched words into a small fetch queue. It presents instructions to decode with a valid/ready handshake, and handles stalls, redirects (branch/jump) and out-of-range fetches. It sits between the instruction ROM and the decode/register-file stage.

Parameters:
RESET_PC, 16'h0000, PC value loaded on reset
IMEM_DEPTH, 512, ROM words; must be a power of two
FQ_DEPTH, 2, fetch-queue entries (≥1)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start_i  input  1  one-cycle pulse; leave IDLE and begin fetching
redirect_valid_i  input  1  branch/jump taken this cycle
redirect_pc_i  input  16  redirect target word address
imem_addr_o  output  16  ROM word address
imem_oe_o  output  1  ROM output enable
imem_data_i  input  16  ROM read data; combinational from address; Z when OE=0
instr_valid_o  output  1  queue head valid
instr_o  output  16  queue head instruction
instr_pc_o  output  16  queue head PC
instr_ready_i  input  1  decode accepts head
busy_o  output  1  state≠IDLE or queue non-empty
fault_o  output  1  fetch out of range (see Optional Feature)

Behaviour:
- Reset, asynchronous, takes effect immediately:
  - state=IDLE, pc=RESET_PC, queue empty
  - all outputs 0: imem_addr_o, imem_oe_o, instr_valid_o, instr_o, instr_pc_o, busy_o, fault_o
- FSM states: IDLE, RUN, FAULT.
  - IDLE: oe=0. start_i → RUN. redirect loads pc and stays IDLE.
  - RUN: issue rule below.
  - FAULT: oe=0, pc holds. redirect clears fault, loads pc, → RUN. start_i is ignored.
- Issue rule in RUN: imem_oe_o=1 iff count<FQ_DEPTH, or (count==FQ_DEPTH and head pop this cycle), and no redirect this cycle.
  - imem_addr_o=pc, registered.
  - On the clock edge with oe=1: push {pc, imem_data_i}; pc←pc+1, 16-bit wrap (0xFFFF→0x0000).
- Latency: word at address A appears on instr_o/instr_pc_o the cycle after imem_addr_o=A with oe=1.
- Pop: on the edge where instr_valid_o && instr_ready_i. Push and pop together when full is legal; count is unchanged.
- Stall: queue full with no pop → oe=0, pc and imem_addr_o hold.
- imem_data_i is sampled only when oe=1; Z is tolerated otherwise.
- Redirect has highest priority over push, pop and start:
  - same cycle: oe=0, no push
  - edge: queue flushed, pc←redirect_pc_i, imem_addr_o←redirect_pc_i
  - next cycle: instr_valid_o=0; fetch resumes
  - A head popped in the redirect cycle counts as consumed by decode.
- Empty queue: instr_o=0, instr_pc_o=0.
- FAULT drains normally: entries already queued remain poppable.

Optional Feature:
Macro FETCH_BOUNDS_CHECK_EN.
- Defined:
  - Issue when pc≥IMEM_DEPTH is suppressed; state→FAULT; fault_o=1 (registered) until redirect or reset.
  - Redirect to an out-of-range target enters FAULT on the following cycle.
- Undefined:
  - imem_addr_o = pc mod IMEM_DEPTH (upper bits zeroed); pc itself still counts 16-bit.
  - FAULT is unreachable; fault_o tied 0.

Decomposition:
- Package imem_fetch_pkg:
  - fetch_state_e {IDLE, RUN, FAULT}
  - fq_entry_t struct {pc[15:0], instr[15:0]}
  - constants: PC_W=16, INSTR_W=16, NOP_INSTR=16'h0000
- Sub-module fetch_queue: parameterised FQ_DEPTH FIFO of fq_entry_t.
  - Interfaces: push/pop/flush, count, head.
  - Simultaneous push+pop when full.
- FSM and PC logic stay in imem_fetch_ctrl.

Test Plan:
1. Reset, start_i pulse, ready=1, ROM[0..2]=F051,80E0,F027 → instr_pc_o 0,1,2 on consecutive cycles with matching data, first valid 1 cycle after addr=0 issued.
2. ready=0 for 6 cycles after start → two entries queued, oe=0, imem_addr_o holds 2; ready=1 → PCs 0,1,2,3… with no loss or duplication.
3. Queue full, redirect to 0x0004 → next cycle instr_valid_o=0; following cycle instr_pc_o=4, instr_o=ROM[4]; old entries never presented.
4. Redirect and pop in the same cycle → head counted consumed, flush wins, next valid entry has instr_pc_o = target.
5. With FETCH_BOUNDS_CHECK_EN: redirect to 0x01FF → 0x1FF fetched, then fault_o=1, oe=0; redirect to 0 clears fault. Without it: redirect 0x0200 → imem_addr_o=0x0000, fault_o=0.
6. Assert rst mid-RUN with a non-empty queue → all outputs 0 immediately (asynchronously); after release, state IDLE, pc=RESET_PC; start_i restarts at RESET_PC.

Source files
------------

// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package imem_fetch_pkg;
  localparam int PC_W    = 16;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fq_entry_t;
endpackage

// File: rtl/imem_fetch_ctrl_fetch_queue.sv
// Small ring-buffer FIFO of fetched {pc, instr} entries with flush.
// Push and pop in the same cycle are legal, including when full.
module fetch_queue
  import imem_fetch_pkg::*;
#(
  parameter int FQ_DEPTH = 2,
  parameter int CNT_W    = $clog2(FQ_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  fq_entry_t        push_data,
  input  logic             pop,
  input  logic             flush,
  output logic [CNT_W-1:0] count,
  output fq_entry_t        head
);
  localparam int PTR_W = (FQ_DEPTH > 1) ? $clog2(FQ_DEPTH) : 1;

  fq_entry_t        mem [FQ_DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FQ_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign head = mem[rd_ptr];

  // Storage: when full with push+pop, the slot written is the one being popped.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= push_data;
  end

  // Pointers and occupancy; flush discards everything.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_inc(wr_ptr);
      if (pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (push && !pop)      count <= count + CNT_W'(1);
      else if (pop && !push) count <= count - CNT_W'(1);
    end
  end
endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer for the combinational instruction ROM: owns the PC,
// issues ROM reads into a fetch queue, and hands words to decode.
// Optional FETCH_BOUNDS_CHECK_EN: out-of-range fetches park in FAULT;
// without it the ROM address wraps modulo IMEM_DEPTH.
module imem_fetch_ctrl
  import imem_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 16'h0000,
  parameter int              IMEM_DEPTH = 512,
  parameter int              FQ_DEPTH   = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_i,
  input  logic               redirect_valid_i,
  input  logic [PC_W-1:0]    redirect_pc_i,
  output logic [PC_W-1:0]    imem_addr_o,
  output logic               imem_oe_o,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic               instr_valid_o,
  output logic [INSTR_W-1:0] instr_o,
  output logic [PC_W-1:0]    instr_pc_o,
  input  logic               instr_ready_i,
  output logic               busy_o,
  output logic               fault_o
);
  localparam int CNT_W = $clog2(FQ_DEPTH + 1);

  fetch_state_e     state, state_nxt;
  logic [PC_W-1:0]  pc, pc_nxt;
  logic [CNT_W-1:0] fq_count;
  fq_entry_t        head, push_entry;
  logic             pop, room, in_range;

  assign pop  = instr_valid_o && instr_ready_i;
  // A full queue still has room when its head leaves this cycle.
  assign room = (fq_count < CNT_W'(FQ_DEPTH)) || pop;

`ifdef FETCH_BOUNDS_CHECK_EN
  assign in_range = ({1'b0, pc} < 17'(IMEM_DEPTH));
  assign fault_o  = (state == FAULT);
`else
  assign in_range = 1'b1;
  assign fault_o  = 1'b0;
`endif

  assign push_entry = '{pc: pc, instr: imem_data_i};

  fetch_queue #(.FQ_DEPTH(FQ_DEPTH)) u_fq (
    .clk       (clk),
    .rst       (rst),
    .push      (imem_oe_o),
    .push_data (push_entry),
    .pop       (pop),
    .flush     (redirect_valid_i),
    .count     (fq_count),
    .head      (head)
  );

  assign instr_valid_o = (fq_count != '0);
  assign instr_o       = instr_valid_o ? head.instr : NOP_INSTR;
  assign instr_pc_o    = instr_valid_o ? head.pc : '0;
  assign busy_o        = (state != IDLE) || instr_valid_o;

  // State, PC and registered ROM address.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      imem_addr_o <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
`ifdef FETCH_BOUNDS_CHECK_EN
      imem_addr_o <= pc_nxt;
`else
      imem_addr_o <= pc_nxt & PC_W'(IMEM_DEPTH - 1);
`endif
    end
  end

  // Next state: redirect outranks start; out-of-range PC in RUN faults.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (!redirect_valid_i && start_i) state_nxt = RUN;
      RUN:     if (!redirect_valid_i && !in_range) state_nxt = FAULT;
      FAULT:   if (redirect_valid_i) state_nxt = RUN;
      default: state_nxt = IDLE;
    endcase
  end

  // Issue decision and PC advance.
  always_comb begin
    imem_oe_o = (state == RUN) && !redirect_valid_i && room && in_range;
    pc_nxt    = pc;
    if (redirect_valid_i) pc_nxt = redirect_pc_i;
    else if (imem_oe_o)   pc_nxt = pc + PC_W'(1);
  end
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl with a behavioural ROM.
module tb_imem_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start_i, redirect_valid_i, instr_ready_i;
  logic [15:0] redirect_pc_i, imem_addr_o, imem_data_i, instr_o, instr_pc_o;
  logic        imem_oe_o, instr_valid_o, busy_o, fault_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  imem_fetch_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_addr_o      (imem_addr_o),
    .imem_oe_o        (imem_oe_o),
    .imem_data_i      (imem_data_i),
    .instr_valid_o    (instr_valid_o),
    .instr_o          (instr_o),
    .instr_pc_o       (instr_pc_o),
    .instr_ready_i    (instr_ready_i),
    .busy_o           (busy_o),
    .fault_o          (fault_o)
  );

  // ROM contents: three fixed words, then a pattern derived from the address.
  function automatic logic [15:0] romv(input logic [15:0] a);
    logic [8:0] w;
    w = a[8:0];
    case (w)
      9'd0: return 16'hF051;
      9'd1: return 16'h80E0;
      9'd2: return 16'hF027;
      default: return {w[7:0] ^ 8'h5A, w[7:0]} ^ {15'd0, w[8]};
    endcase
  endfunction

  assign imem_data_i = imem_oe_o ? romv(imem_addr_o) : 16'h0000;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".addr"},  32'(imem_addr_o), 32'h0);
    chk({tag, ".oe"},    32'(imem_oe_o), 32'h0);
    chk({tag, ".valid"}, 32'(instr_valid_o), 32'h0);
    chk({tag, ".instr"}, 32'(instr_o), 32'h0);
    chk({tag, ".ipc"},   32'(instr_pc_o), 32'h0);
    chk({tag, ".busy"},  32'(busy_o), 32'h0);
    chk({tag, ".fault"}, 32'(fault_o), 32'h0);
  endtask

  task automatic chk_head(input string tag, input logic [15:0] p);
    chk({tag, ".valid"}, 32'(instr_valid_o), 32'h1);
    chk({tag, ".ipc"},   32'(instr_pc_o), 32'(p));
    chk({tag, ".instr"}, 32'(instr_o), 32'(romv(p)));
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; redirect_valid_i = 1'b0;
    redirect_pc_i = 16'h0; instr_ready_i = 1'b0;
    step(2);
    chk_zero("reset");
    rst = 1'b0;
    step();

    // 1: streaming fetch with decode always ready
    instr_ready_i = 1'b1; start_i = 1'b1;
    step();
    start_i = 1'b0;
    chk("t1.busy",  32'(busy_o), 32'h1);
    chk("t1.addr0", 32'(imem_addr_o), 32'h0);
    chk("t1.oe0",   32'(imem_oe_o), 32'h1);
    chk("t1.nv0",   32'(instr_valid_o), 32'h0);
    step(); chk_head("t1.h0", 16'd0); chk("t1.addr1", 32'(imem_addr_o), 32'h1);
    step(); chk_head("t1.h1", 16'd1);
    step(); chk_head("t1.h2", 16'd2);

    // 2: stall with decode not ready, then drain in order
    rst = 1'b1; step(); rst = 1'b0; instr_ready_i = 1'b0;
    start_i = 1'b1; step(); start_i = 1'b0;
    step(6);
    chk("t2.oe",   32'(imem_oe_o), 32'h0);
    chk("t2.addr", 32'(imem_addr_o), 32'h2);
    chk_head("t2.full", 16'd0);
    instr_ready_i = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk_head($sformatf("t2.h%0d", k), 16'(k));
      step();
    end

    // 3: redirect with a full queue
    instr_ready_i = 1'b0;
    step(2);
    chk("t3.oe_full", 32'(imem_oe_o), 32'h0);
    chk("t3.addr",    32'(imem_addr_o), 32'h8);
    redirect_valid_i = 1'b1; redirect_pc_i = 16'h0004;
    #1 chk("t3.oe_redir", 32'(imem_oe_o), 32'h0);
    step(); redirect_valid_i = 1'b0;
    chk("t3.nv",    32'(instr_valid_o), 32'h0);
    chk("t3.raddr", 32'(imem_addr_o), 32'h4);
    step(); chk_head("t3.h4", 16'd4);

    // 4: redirect and pop in the same cycle
    instr_ready_i = 1'b1; redirect_valid_i = 1'b1; redirect_pc_i = 16'h0010;
    step(); redirect_valid_i = 1'b0;
    chk("t4.nv", 32'(instr_valid_o), 32'h0);
    step(); chk_head("t4.h10", 16'h0010);
    step(); chk_head("t4.h11", 16'h0011);

    // 5: end of ROM
`ifdef FETCH_BOUNDS_CHECK_EN
    redirect_valid_i = 1'b1; redirect_pc_i = 16'h01FF;
    step(); redirect_valid_i = 1'b0;
    chk("t5.addr", 32'(imem_addr_o), 32'h1FF);
    chk("t5.oe",   32'(imem_oe_o), 32'h1);
    step(); chk_head("t5.h1ff", 16'h01FF);
    chk("t5.oe_off", 32'(imem_oe_o), 32'h0);
    step();
    chk("t5.fault", 32'(fault_o), 32'h1);
    chk("t5.oe_f",  32'(imem_oe_o), 32'h0);
    redirect_valid_i = 1'b1; redirect_pc_i = 16'h0000;
    step(); redirect_valid_i = 1'b0;
    chk("t5.clr",  32'(fault_o), 32'h0);
    chk("t5.oe_r", 32'(imem_oe_o), 32'h1);
    step(); chk_head("t5.h0", 16'h0000);
`else
    redirect_valid_i = 1'b1; redirect_pc_i = 16'h0200;
    step(); redirect_valid_i = 1'b0;
    chk("t5.wrap",  32'(imem_addr_o), 32'h0);
    chk("t5.fault", 32'(fault_o), 32'h0);
    step();
    chk("t5.ipc",   32'(instr_pc_o), 32'h0200);
    chk("t5.instr", 32'(instr_o), 32'(romv(16'h0)));
`endif

    // 6: asynchronous reset mid-run with a non-empty queue
    instr_ready_i = 1'b0;
    step(3);
    chk("t6.pre", 32'(instr_valid_o), 32'h1);
    #2 rst = 1'b1;
    #1 chk_zero("t6.async");
    step(); rst = 1'b0;
    step(2);
    chk("t6.idle_oe", 32'(imem_oe_o), 32'h0);
    chk("t6.idle_bs", 32'(busy_o), 32'h0);
    instr_ready_i = 1'b1; start_i = 1'b1;
    step(); start_i = 1'b0;
    chk("t6.addr", 32'(imem_addr_o), 32'h0);
    step(); chk_head("t6.h0", 16'h0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end
endmodule
